mmss_time_keeper_set: RTL and testbench

//  Time base and time-setting stage for the mm:ss digital clock. Holds binary seconds/minutes
//  (0..59), advances them once per second from an internal prescaler, and lets the user set
//  the time with three push buttons. Feeds the digit separator / 7-seg mux stages downstream.

---
 rtl/mmss_time_keeper_set.sv | 164 ++++++++++++++++
 tb/tb_mmss_time_keeper_set.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmss_time_keeper_set.sv
// ============================================================================
// mmss_time_keeper_set : mm:ss time base with prescaler, debounced buttons and
//                        RUN / SET_MIN / SET_SEC time-setting FSM
// Revision : 1.0
// ============================================================================
`default_nettype none

module mmss_time_keeper_set #(
    parameter int TICK_DIV     = 100_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int BLINK_DIV    = 25_000_000
) (
    input  logic       clk,
    input  logic       Resetn,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic [1:0] mode,
    output logic       blink,
    output logic       tick
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_MIN = 2'b01,
        SET_SEC = 2'b10
    } state_e;

    state_e        state_q;
    logic [TW-1:0] presc_q;
    logic [BW-1:0] blink_cnt_q;
    logic [5:0]    sec_q;
    logic [5:0]    min_q;
    logic          blink_q;
    logic          tick_q;

    logic [2:0] btn_raw;
    logic [2:0] press;
    logic       mode_p;
    logic       up_p;
    logic       dn_p;

    assign btn_raw = {btn_down, btn_up, btn_mode};

    // Per button: 2-FF synchroniser, stability counter, rising-edge detect.
    generate
        for (genvar i = 0; i < 3; i++) begin : g_btn
            logic          sync1_q;
            logic          sync2_q;
            logic          level_q;
            logic          prev_q;
            logic [DW-1:0] cnt_q;

            always_ff @(posedge clk or negedge Resetn) begin
                if (!Resetn) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    level_q <= 1'b0;
                    prev_q  <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= btn_raw[i];
                    sync2_q <= sync1_q;
                    prev_q  <= level_q;
                    if (sync2_q == level_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == DW'(DEBOUNCE_CYC - 1)) begin
                        level_q <= sync2_q;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            end

            assign press[i] = level_q & ~prev_q;
        end
    endgenerate

    // Mode wins over up/down; up and down together cancel.
    assign mode_p = press[0];
    assign up_p   = press[1] & ~press[2] & ~press[0];
    assign dn_p   = press[2] & ~press[1] & ~press[0];

    function automatic logic [5:0] inc59(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] dec59(input logic [5:0] v);
        return (v == 6'd0) ? 6'd59 : v - 6'd1;
    endfunction

    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= RUN;
            presc_q     <= '0;
            blink_cnt_q <= '0;
            sec_q       <= '0;
            min_q       <= '0;
            blink_q     <= 1'b1;
            tick_q      <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            case (state_q)
                RUN: begin
                    blink_q     <= 1'b1;
                    blink_cnt_q <= '0;
                    if (mode_p) begin
                        state_q <= SET_MIN;
                        presc_q <= '0;
                    end else if (presc_q == TW'(TICK_DIV - 1)) begin
                        presc_q <= '0;
                        tick_q  <= 1'b1;
                        sec_q   <= inc59(sec_q);
                        if (sec_q == 6'd59) begin
                            min_q <= inc59(min_q);
                        end
                    end else begin
                        presc_q <= presc_q + 1'b1;
                    end
                end
                SET_MIN, SET_SEC: begin
                    presc_q <= '0;
                    if (mode_p) begin
                        state_q     <= (state_q == SET_MIN) ? SET_SEC : RUN;
                        blink_q     <= 1'b1;
                        blink_cnt_q <= '0;
                    end else if (up_p || dn_p) begin
                        if (state_q == SET_MIN) begin
                            min_q <= up_p ? inc59(min_q) : dec59(min_q);
                        end else begin
                            sec_q <= up_p ? inc59(sec_q) : dec59(sec_q);
                        end
                        blink_q     <= 1'b1;
                        blink_cnt_q <= '0;
                    end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
                        blink_q     <= ~blink_q;
                        blink_cnt_q <= '0;
                    end else begin
                        blink_cnt_q <= blink_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign seconds = sec_q;
    assign minutes = min_q;
    assign mode    = state_q;
    assign blink   = blink_q;
    assign tick    = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_mmss_time_keeper_set.sv
// ============================================================================
// tb_mmss_time_keeper_set : directed bench for the mm:ss time keeper
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mmss_time_keeper_set;

    logic       clk;
    logic       Resetn;
    logic       btn_mode;
    logic       btn_up;
    logic       btn_down;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [1:0] mode;
    logic       blink;
    logic       tick;

    int n_chk;
    int n_pass;

    mmss_time_keeper_set #(
        .TICK_DIV     (10),
        .DEBOUNCE_CYC (4),
        .BLINK_DIV    (5)
    ) dut (
        .clk      (clk),
        .Resetn   (Resetn),
        .btn_mode (btn_mode),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .seconds  (seconds),
        .minutes  (minutes),
        .mode     (mode),
        .blink    (blink),
        .tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int btn;    // 0 mode, 1 up, 2 down
        int e_mode;
        int e_min;
        int e_sec;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       btn_mode = v;
            1:       btn_up   = v;
            default: btn_down = v;
        endcase
    endtask

    // Clean press: accepted on the 7th edge, held 12 cycles, then 12 released.
    task automatic press(input int b, input int e_mode, input int e_min,
                         input int e_sec, input string nm);
        set_btn(b, 1'b1);
        step(7);
        chk({nm, "_mode"},  int'(mode),    e_mode);
        chk({nm, "_min"},   int'(minutes), e_min);
        chk({nm, "_sec"},   int'(seconds), e_sec);
        chk({nm, "_blink"}, int'(blink),   1);
        step(5);
        set_btn(b, 1'b0);
        step(12);
    endtask

    task automatic chk_all(input string nm, input int s, input int m,
                           input int md, input int bl, input int tk);
        chk({nm, "_sec"},   int'(seconds), s);
        chk({nm, "_min"},   int'(minutes), m);
        chk({nm, "_mode"},  int'(mode),    md);
        chk({nm, "_blink"}, int'(blink),   bl);
        chk({nm, "_tick"},  int'(tick),    tk);
    endtask

    initial begin
        int ticks;
        int bad_t;
        int bad_s;
        int bad_b;

        n_chk = 0;
        n_pass = 0;
        Resetn = 1'b0;
        btn_mode = 1'b0;
        btn_up = 1'b0;
        btn_down = 1'b0;

        tbl[0]  = '{1, 1, 0, 7};
        tbl[1]  = '{1, 1, 1, 7};
        tbl[2]  = '{2, 1, 0, 7};
        tbl[3]  = '{2, 1, 59, 7};
        tbl[4]  = '{1, 1, 0, 7};
        tbl[5]  = '{0, 2, 0, 7};
        tbl[6]  = '{2, 2, 0, 6};
        tbl[7]  = '{2, 2, 0, 5};
        tbl[8]  = '{2, 2, 0, 4};
        tbl[9]  = '{2, 2, 0, 3};
        tbl[10] = '{2, 2, 0, 2};
        tbl[11] = '{2, 2, 0, 1};
        tbl[12] = '{2, 2, 0, 0};
        tbl[13] = '{2, 2, 0, 59};
        tbl[14] = '{2, 2, 0, 58};

        // Reset state, then free-run through a full hour
        step(2);
        chk_all("reset", 0, 0, 0, 1, 0);
        Resetn = 1'b1;
        ticks = 0;
        bad_t = 0;
        bad_s = 0;
        for (int c = 1; c <= 36000; c++) begin
            step(1);
            if (int'(tick) != ((c % 10 == 0) ? 1 : 0)) bad_t++;
            if (c % 10 == 0) ticks++;
            if (int'(seconds) != ticks % 60 || int'(minutes) != (ticks / 60) % 60) bad_s++;
            if (c == 5950) begin
                chk("run_0955_sec", int'(seconds), 55);
                chk("run_0955_min", int'(minutes), 9);
            end
            if (c == 35990) begin
                chk("run_5959_sec", int'(seconds), 59);
                chk("run_5959_min", int'(minutes), 59);
            end
        end
        chk("run_wrap_sec", int'(seconds), 0);
        chk("run_wrap_min", int'(minutes), 0);
        chk("run_wrap_tick", int'(tick), 1);
        chk("run_tick_period_errs", bad_t, 0);
        chk("run_time_track_errs", bad_s, 0);

        step(70);
        chk("run_0007_sec", int'(seconds), 7);

        // Mode press latency, held time, blink cadence in SET_MIN
        btn_mode = 1'b1;
        bad_t = 0;
        bad_s = 0;
        bad_b = 0;
        for (int k = 1; k <= 26; k++) begin
            step(1);
            if (k == 6) chk("set_mode_before_edge7", int'(mode), 0);
            if (k == 7) chk("set_mode_at_edge7", int'(mode), 1);
            if (k >= 7) begin
                if (int'(tick) != 0) bad_t++;
                if (int'(seconds) != 7) bad_s++;
                if (int'(blink) != ((((k - 7) / 5) % 2 == 0) ? 1 : 0)) bad_b++;
            end
            if (k == 12) btn_mode = 1'b0;
        end
        chk("setmin_tick_errs", bad_t, 0);
        chk("setmin_sec_errs", bad_s, 0);
        chk("setmin_blink_errs", bad_b, 0);

        // Down press at minutes=0 lands while blink is low; it must force blink high
        btn_down = 1'b1;
        for (int k = 27; k <= 50; k++) begin
            step(1);
            if (k == 32) begin
                chk("down_min_before", int'(minutes), 0);
                chk("down_blink_before", int'(blink), 0);
            end
            if (k == 33) begin
                chk("down_min_wrap", int'(minutes), 59);
                chk("down_blink_forced", int'(blink), 1);
                chk("down_sec_kept", int'(seconds), 7);
            end
            if (k == 38) begin
                chk("down_blink_restart", int'(blink), 0);
                btn_down = 1'b0;
            end
        end

        for (int i = 0; i < 15; i++) begin
            press(tbl[i].btn, tbl[i].e_mode, tbl[i].e_min, tbl[i].e_sec,
                  $sformatf("vec%0d", i));
        end

        // Bouncing up button in SET_SEC at 58: one increment only
        bad_s = 0;
        for (int k = 0; k < 20; k++) begin
            btn_up = ((k / 2) % 2 == 0);
            step(1);
            if (int'(seconds) != 58) bad_s++;
        end
        chk("bounce_no_incr_errs", bad_s, 0);
        btn_up = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            step(1);
            if (j == 6) chk("bounce_sec_before", int'(seconds), 58);
            if (j == 7) chk("bounce_sec_incr", int'(seconds), 59);
        end
        btn_up = 1'b0;
        step(12);
        chk("bounce_single_incr", int'(seconds), 59);
        press(1, 2, 0, 0, "sec_wrap_up");

        // Back to RUN, up ignored there, then into SET_MIN
        press(0, 0, 0, 0, "to_run");
        press(1, 0, 0, 2, "run_up_ignored");
        press(0, 1, 0, 4, "to_setmin");
        for (int i = 1; i <= 12; i++) begin
            press(1, 1, i, 4, $sformatf("min_up%0d", i));
        end

        // Mode and up rising together: mode advances, minutes unchanged
        btn_mode = 1'b1;
        btn_up = 1'b1;
        step(7);
        chk("mode_up_same_mode", int'(mode), 2);
        chk("mode_up_same_min", int'(minutes), 12);
        step(5);
        btn_mode = 1'b0;
        btn_up = 1'b0;
        step(12);
        chk("mode_up_min_after", int'(minutes), 12);

        // Up and down together cancel
        btn_up = 1'b1;
        btn_down = 1'b1;
        step(7);
        chk("up_down_same_sec", int'(seconds), 4);
        step(5);
        btn_up = 1'b0;
        btn_down = 1'b0;
        step(12);
        chk("up_down_same_sec_after", int'(seconds), 4);

        for (int i = 5; i <= 30; i++) begin
            press(1, 2, 12, i, $sformatf("sec_up%0d", i));
        end

        // Asynchronous reset between edges, then restart timing
        #2;
        Resetn = 1'b0;
        #1;
        chk_all("async_reset", 0, 0, 0, 1, 0);
        step(2);
        Resetn = 1'b1;
        step(9);
        chk("rst_rel_tick_early", int'(tick), 0);
        chk("rst_rel_sec_early", int'(seconds), 0);
        step(1);
        chk_all("rst_rel_first_tick", 1, 0, 0, 1, 1);
        step(1);
        chk("rst_rel_tick_pulse", int'(tick), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
